adc_channel_averager: RTL and testbench

ADC_CHANNEL_AVERAGER -- requirements
Module: adc_channel_averager

---
 rtl/adc_avg_pkg.sv | 21 ++
 rtl/adc_avg_channel.sv | 96 +++++++++
 rtl/adc_channel_averager.sv | 126 ++++++++++++
 tb/tb_adc_channel_averager.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_avg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_avg_pkg
// Description : Shared defaults and sizing helpers for the ADC channel averager.
// Revision    : 1.0 - initial release
// ============================================================================
package adc_avg_pkg;

  localparam int CHANNELS_DEF = 4;
  localparam int DATA_W_DEF   = 16;
  localparam int MAX_EXP_DEF  = 8;
  localparam int ACC_W        = DATA_W_DEF + MAX_EXP_DEF;
  localparam int CH_IDX_W     = (CHANNELS_DEF > 1) ? $clog2(CHANNELS_DEF) : 1;

  // Index width that stays legal for a single-channel build.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_avg_channel.sv
`default_nettype none
// ============================================================================
// Module      : adc_avg_channel
// Description : Per-channel accumulator, sample counter, result register,
//               pending flag and sticky overrun flag.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_avg_channel
  import adc_avg_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MAX_EXP = MAX_EXP_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_ready,
  input  logic              i_enable,
  input  logic [DATA_W-1:0] i_sample,
  input  logic [3:0]        i_k,
  input  logic              i_exp_change,
  input  logic              i_drain,
  input  logic              i_clear_overrun,
  output logic [DATA_W-1:0] o_result,
  output logic              o_pending,
  output logic              o_overrun
);

  localparam int SUM_W = DATA_W + MAX_EXP;
  localparam int CNT_W = MAX_EXP + 1;

  logic [SUM_W-1:0]  r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_result;
  logic              r_pending;
  logic              r_overrun;
  logic              r_en_d;

  logic              w_add;
  logic              w_flush;
  logic              w_done;
  logic [SUM_W-1:0]  w_sum;
  logic [SUM_W-1:0]  w_avg;
  logic [CNT_W-1:0]  w_cnt_inc;

  // A sample landing in the exponent-change cycle is dropped along with the partial sum.
  assign w_add     = i_ready & i_enable & ~i_exp_change;
  assign w_flush   = i_exp_change | (r_en_d & ~i_enable);
  assign w_sum     = r_acc + SUM_W'(i_sample);
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_done    = w_add && (w_cnt_inc == (CNT_W'(1) << i_k));
  assign w_avg     = w_sum >> i_k;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_result  <= '0;
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
      r_en_d    <= 1'b0;
    end else begin
      r_en_d <= i_enable;

      if (w_flush || w_done) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (w_add) begin
        r_acc <= w_sum;
        r_cnt <= w_cnt_inc;
      end

      if (w_done) begin
        r_result <= w_avg[DATA_W-1:0];
      end

      if (w_done) begin
        r_pending <= 1'b1;
      end else if (i_drain) begin
        r_pending <= 1'b0;
      end

      // A drain in the same cycle hands the old result out, so nothing is lost.
      if (w_done && r_pending && !i_drain) begin
        r_overrun <= 1'b1;
      end else if (i_clear_overrun) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign o_result  = r_result;
  assign o_pending = r_pending;
  assign o_overrun = r_overrun;

endmodule
`default_nettype wire

// File: rtl/adc_channel_averager.sv
`default_nettype none
// ============================================================================
// Module      : adc_channel_averager
// Description : Block-averages each ADC channel over 2^k samples and funnels
//               completed results through a round-robin arbitrated output slot.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_channel_averager
  import adc_avg_pkg::*;
#(
  parameter int CHANNELS = CHANNELS_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_EXP  = MAX_EXP_DEF
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [CHANNELS*DATA_W-1:0]      adcdata,
  input  logic [CHANNELS-1:0]             adcready,
  input  logic [CHANNELS-1:0]             adc_enable,
  input  logic [3:0]                      avg_exp,
  input  logic                            clear_overrun,
  output logic [DATA_W-1:0]               out_data,
  output logic [idx_width(CHANNELS)-1:0]  out_channel,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [CHANNELS-1:0]             overrun
);

  localparam int CH_W = idx_width(CHANNELS);

  logic [3:0]          r_exp;
  logic [3:0]          w_k;
  logic                w_exp_change;

  logic [CHANNELS-1:0] w_pending;
  logic [CHANNELS-1:0] w_drain;
  logic [DATA_W-1:0]   w_result [CHANNELS];

  logic [DATA_W-1:0]   r_data;
  logic [CH_W-1:0]     r_chan;
  logic                r_valid;
  logic [CH_W-1:0]     r_ptr;

  logic                w_load;
  logic                w_found;
  logic [CH_W-1:0]     w_sel;

  assign w_k          = (int'(avg_exp) > MAX_EXP) ? 4'(MAX_EXP) : avg_exp;
  assign w_exp_change = (avg_exp != r_exp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exp <= '0;
    end else begin
      r_exp <= avg_exp;
    end
  end

  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      assign w_drain[i] = w_load && w_found && (w_sel == CH_W'(i));

      adc_avg_channel #(
        .DATA_W  (DATA_W),
        .MAX_EXP (MAX_EXP)
      ) u_chan (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_ready         (adcready[i]),
        .i_enable        (adc_enable[i]),
        .i_sample        (adcdata[i*DATA_W +: DATA_W]),
        .i_k             (w_k),
        .i_exp_change    (w_exp_change),
        .i_drain         (w_drain[i]),
        .i_clear_overrun (clear_overrun),
        .o_result        (w_result[i]),
        .o_pending       (w_pending[i]),
        .o_overrun       (overrun[i])
      );
    end
  endgenerate

  // Walk from the far end back toward r_ptr so the closest pending channel wins.
  always_comb begin
    int w_idx;
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = 0;
    for (int off = CHANNELS - 1; off >= 0; off--) begin
      w_idx = int'(r_ptr) + off;
      if (w_idx >= CHANNELS) begin
        w_idx = w_idx - CHANNELS;
      end
      if (w_pending[CH_W'(w_idx)]) begin
        w_found = 1'b1;
        w_sel   = CH_W'(w_idx);
      end
    end
  end

  assign w_load = !r_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_chan  <= '0;
      r_valid <= 1'b0;
      r_ptr   <= '0;
    end else if (w_load) begin
      if (w_found) begin
        r_data  <= w_result[w_sel];
        r_chan  <= w_sel;
        r_valid <= 1'b1;
        r_ptr   <= (w_sel == CH_W'(CHANNELS - 1)) ? '0 : w_sel + 1'b1;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_data    = r_data;
  assign out_channel = r_chan;
  assign out_valid   = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_adc_channel_averager.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_channel_averager
// Description : Scoreboard bench; a sample-queue average model feeds per-channel
//               expected-result queues that a monitor drains on each transfer.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_adc_channel_averager;

  localparam int CH = 4;
  localparam int DW = 16;
  localparam int ME = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [CH*DW-1:0] adcdata;
  logic [CH-1:0]    adcready;
  logic [CH-1:0]    adc_enable;
  logic [3:0]       avg_exp;
  logic             clear_overrun;
  logic [DW-1:0]    out_data;
  logic [1:0]       out_channel;
  logic             out_valid;
  logic             out_ready;
  logic [CH-1:0]    overrun;

  adc_channel_averager #(.CHANNELS(CH), .DATA_W(DW), .MAX_EXP(ME)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .adcdata       (adcdata),
    .adcready      (adcready),
    .adc_enable    (adc_enable),
    .avg_exp       (avg_exp),
    .clear_overrun (clear_overrun),
    .out_data      (out_data),
    .out_channel   (out_channel),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int exp_q  [CH][$];
  int samp_q [CH][$];
  int xfer_ch[$];
  int xfer_cyc[$];
  int cur_exp;
  logic [CH-1:0] cur_en;

  task automatic check(input string name, input longint act, input longint expv);
    n_checks++;
    if (act != expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic int k_eff();
    return (cur_exp > ME) ? ME : cur_exp;
  endfunction

  function automatic int total_expected();
    int s = 0;
    for (int i = 0; i < CH; i++) s += exp_q[i].size();
    return s;
  endfunction

  function automatic logic [CH*DW-1:0] pk(input int ch, input int v);
    logic [CH*DW-1:0] d;
    d = '0;
    d[ch*DW +: DW] = DW'(v);
    return d;
  endfunction

  // Reference: a window is simply the last 2^k accepted samples, averaged with truncation.
  task automatic model_add(input int ch, input int v);
    longint s;
    int n;
    if (!cur_en[ch]) return;
    samp_q[ch].push_back(v);
    n = 1 << k_eff();
    if (samp_q[ch].size() == n) begin
      s = 0;
      for (int j = 0; j < samp_q[ch].size(); j++) s += samp_q[ch][j];
      exp_q[ch].push_back(int'(s / n));
      samp_q[ch].delete();
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [CH-1:0] rdy, input logic [CH*DW-1:0] data);
    adcready = rdy;
    adcdata  = data;
    for (int i = 0; i < CH; i++)
      if (rdy[i]) model_add(i, int'(data[i*DW +: DW]));
    tick(1);
    adcready = '0;
  endtask

  task automatic set_cfg(input int e, input logic [CH-1:0] en);
    if (e != cur_exp)
      for (int i = 0; i < CH; i++) samp_q[i].delete();
    for (int i = 0; i < CH; i++)
      if (cur_en[i] && !en[i]) samp_q[i].delete();
    avg_exp    = 4'(e);
    adc_enable = en;
    cur_exp    = e;
    cur_en     = en;
    tick(1);
  endtask

  task automatic clear_model();
    for (int i = 0; i < CH; i++) begin
      samp_q[i].delete();
      exp_q[i].delete();
    end
  endtask

  // Monitor: pops the channel's expected queue on every transfer and checks hold stability.
  initial begin : monitor
    logic          held;
    logic [DW-1:0] hd;
    logic [1:0]    hc;
    held = 1'b0;
    hd   = '0;
    hc   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
      end else begin
        if (held) begin
          check("hold_valid", out_valid, 1);
          check("hold_data", out_data, hd);
          check("hold_chan", out_channel, hc);
        end
        if (out_valid && out_ready) begin
          xfer_ch.push_back(int'(out_channel));
          xfer_cyc.push_back(cyc);
          if (exp_q[out_channel].size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_output: chan %0d data %0d, nothing expected", out_channel, out_data);
          end else begin
            check($sformatf("out_data_ch%0d", out_channel), out_data, exp_q[out_channel].pop_front());
          end
          held = 1'b0;
        end else if (out_valid) begin
          held = 1'b1;
          hd   = out_data;
          hc   = out_channel;
        end else begin
          held = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int last[CH];
    logic [CH-1:0] rdy;
    logic prev_low;

    rst_n = 1'b0; adcdata = '0; adcready = '0; adc_enable = '0;
    avg_exp = '0; clear_overrun = 1'b0; out_ready = 1'b1;
    cur_exp = 0; cur_en = '0;
    tick(3);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_out_channel", out_channel, 0);
    check("reset_overrun", overrun, 0);
    rst_n = 1'b1;
    tick(2);

    // Pass-through burst on all channels, fresh arbiter pointer.
    set_cfg(0, 4'b1111);
    xfer_ch.delete(); xfer_cyc.delete();
    drive(4'b1111, {16'd4, 16'd3, 16'd2, 16'd1});
    tick(6);
    check("burst_count", xfer_ch.size(), 4);
    if (xfer_ch.size() == 4)
      for (int i = 0; i < 4; i++) begin
        check("burst_order", xfer_ch[i], i);
        check("burst_cycle", xfer_cyc[i] - xfer_cyc[0], i);
      end

    // Backpressure: slot holds result 1, result 2 pends, result 3 overwrites it.
    set_cfg(1, 4'b0100);
    out_ready = 1'b0;
    drive(4'b0100, pk(2, 100)); drive(4'b0100, pk(2, 200));
    drive(4'b0100, pk(2, 10));  drive(4'b0100, pk(2, 30));
    drive(4'b0100, pk(2, 7));   drive(4'b0100, pk(2, 8));
    tick(2);
    check("ovr_valid", out_valid, 1);
    check("ovr_chan", out_channel, 2);
    check("ovr_data", out_data, 150);
    check("ovr_flag", overrun, 4'b0100);
    check("ovr_model_depth", exp_q[2].size(), 3);
    if (exp_q[2].size() == 3) exp_q[2].delete(1);
    clear_overrun = 1'b1;
    tick(1);
    clear_overrun = 1'b0;
    check("ovr_cleared", overrun, 0);
    out_ready = 1'b1;
    tick(4);
    check("ovr_drained", exp_q[2].size(), 0);

    // Four-sample window with latency check.
    set_cfg(2, 4'b0001);
    drive(4'b0001, pk(0, 10)); drive(4'b0001, pk(0, 20)); drive(4'b0001, pk(0, 30));
    drive(4'b0001, pk(0, 41));
    @(negedge clk);
    check("lat_not_yet", out_valid, 0);
    @(negedge clk);
    check("lat_valid", out_valid, 1);
    check("lat_chan", out_channel, 0);
    check("lat_data", out_data, 25);
    @(posedge clk); #1;
    tick(2);

    // Largest window at full scale, then a clamped exponent with random data.
    set_cfg(8, 4'b0010);
    for (int i = 0; i < 256; i++) drive(4'b0010, pk(1, 16'hFFFF));
    tick(3);
    check("k8_drained", exp_q[1].size(), 0);
    set_cfg(15, 4'b0010);
    for (int i = 0; i < 256; i++) drive(4'b0010, pk(1, int'($urandom_range(0, 65535))));
    tick(3);
    check("clamp_drained", exp_q[1].size(), 0);

    // Exponent change mid-window discards the partial sum.
    set_cfg(3, 4'b0001);
    for (int i = 0; i < 5; i++) drive(4'b0001, pk(0, 1000 + i * 37));
    set_cfg(1, 4'b0001);
    drive(4'b0001, pk(0, 500));
    tick(2);
    check("expchg_no_early", out_valid, 0);
    drive(4'b0001, pk(0, 901));
    tick(3);
    check("expchg_drained", exp_q[0].size(), 0);

    // Reset while a result is held and a partial window is in progress.
    set_cfg(2, 4'b1000);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) drive(4'b1000, pk(3, 200 + i));
    tick(2);
    check("rst_pre_valid", out_valid, 1);
    for (int i = 0; i < 3; i++) drive(4'b1000, pk(3, 9000));
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", out_valid, 0);
    check("rst_async_overrun", overrun, 0);
    clear_model();
    tick(1);
    rst_n = 1'b1;
    tick(2);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) drive(4'b1000, pk(3, 60 + i));
    tick(3);
    check("rst_fresh_partial", out_valid, 0);
    drive(4'b1000, pk(3, 77));
    tick(3);
    check("rst_fresh_drained", exp_q[3].size(), 0);

    // Random segments; per-channel sample spacing keeps every result drainable.
    for (int i = 0; i < CH; i++) last[i] = -100;
    prev_low = 1'b0;
    for (int seg = 0; seg < 8; seg++) begin
      out_ready = 1'b1;
      prev_low  = 1'b0;
      set_cfg(int'($urandom_range(0, 4)), 4'($urandom_range(0, 15)));
      for (int c = 0; c < 150; c++) begin
        rdy = '0;
        for (int i = 0; i < CH; i++)
          if ((cyc - last[i] >= 16) && ($urandom_range(0, 3) == 0)) begin
            rdy[i]  = 1'b1;
            last[i] = cyc;
          end
        out_ready = prev_low ? 1'b1 : ($urandom_range(0, 3) != 0);
        prev_low  = !out_ready;
        drive(rdy, {$urandom, $urandom});
      end
    end
    out_ready = 1'b1;
    for (int t = 0; t < 300 && (total_expected() > 0 || out_valid); t++) tick(1);
    check("final_all_drained", total_expected(), 0);
    check("final_no_overrun", overrun, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
